// File: rtl/reset_sequencer.sv
// Reset sequencer: after a power-on wait, releases four peripheral resets one
// stage at a time. Each stage must acknowledge on periph_ready within a timeout,
// and then gets a settle gap before the next stage is released. Once every
// stage is out of reset, all released stages are watched continuously. If any of
// them drops ready, or a stage times out, every peripheral reset is re-asserted
// and the sequencer parks in FAULT until restart or rst_n.
//
// Ports:
//   clk_50m       in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   restart       in   synchronous single-cycle soft restart, highest priority
//   periph_ready  in   [3:0] per-stage ready, asynchronous (2-flop synchronized)
//   periph_rst_n  out  [3:0] per-stage active-low peripheral resets, registered
//   seq_done      out  all stages released and healthy, registered
//   seq_fault     out  sequencer in FAULT, registered
//   fault_stage   out  [1:0] failing stage index, valid while seq_fault=1
module reset_sequencer #(
    parameter logic [23:0] POR_CYCLES     = 24'd2500000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000,
    parameter logic [23:0] GAP_CYCLES     = 24'd50000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       restart,
    input  logic [3:0] periph_ready,
    output logic [3:0] periph_rst_n,
    output logic       seq_done,
    output logic       seq_fault,
    output logic [1:0] fault_stage
);

    typedef enum logic [2:0] {
        StPor,
        StRelease,
        StWaitRdy,
        StGap,
        StDone,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  stg_q, stg_d;
    logic [3:0]  prst_q, prst_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [1:0]  fstage_q, fstage_d;

    logic [3:0]  rdy_meta_q, rdy_sync_q;

    logic [3:0]  watch_mask;
    logic [3:0]  drop;
    logic [1:0]  drop_idx;

    // Two-flop synchronizer per ready bit.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rdy_meta_q <= 4'b0000;
            rdy_sync_q <= 4'b0000;
        end else begin
            rdy_meta_q <= periph_ready;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    // Stages that must stay ready: those below stg, plus stg itself once its
    // ready has been seen (i.e. in GAP and DONE, not in WAIT_RDY).
    always_comb begin
        watch_mask = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            if (2'(j) < stg_q) begin
                watch_mask[j] = 1'b1;
            end else if ((2'(j) == stg_q) && (state_q == StGap || state_q == StDone)) begin
                watch_mask[j] = 1'b1;
            end
        end
        if (!(state_q == StWaitRdy || state_q == StGap || state_q == StDone)) begin
            watch_mask = 4'b0000;
        end
    end

    assign drop = watch_mask & ~rdy_sync_q;

    // Lowest dropped stage wins.
    always_comb begin
        drop_idx = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (drop[j]) begin
                drop_idx = 2'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stg_d    = stg_q;
        prst_d   = prst_q;
        done_d   = done_q;
        fault_d  = fault_q;
        fstage_d = fstage_q;

        if (restart) begin
            state_d  = StPor;
            cnt_d    = 24'd0;
            stg_d    = 2'd0;
            prst_d   = 4'b0000;
            done_d   = 1'b0;
            fault_d  = 1'b0;
            fstage_d = 2'd0;
        end else if (drop != 4'b0000) begin
            state_d  = StFault;
            prst_d   = 4'b0000;
            done_d   = 1'b0;
            fault_d  = 1'b1;
            fstage_d = drop_idx;
        end else begin
            case (state_q)
                StPor: begin
                    if (cnt_q == POR_CYCLES - 24'd1) begin
                        state_d = StRelease;
                        cnt_d   = 24'd0;
                        stg_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                StRelease: begin
                    prst_d[stg_q] = 1'b1;
                    state_d       = StWaitRdy;
                    cnt_d         = 24'd0;
                end
                StWaitRdy: begin
                    // Ready is tested first so it wins over a same-cycle timeout.
                    if (rdy_sync_q[stg_q]) begin
                        state_d = StGap;
                        cnt_d   = 24'd0;
                    end else if (cnt_q == TIMEOUT_CYCLES - 24'd1) begin
                        state_d  = StFault;
                        prst_d   = 4'b0000;
                        done_d   = 1'b0;
                        fault_d  = 1'b1;
                        fstage_d = stg_q;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == GAP_CYCLES - 24'd1) begin
                        cnt_d = 24'd0;
                        if (stg_q == 2'd3) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                            prst_d  = 4'b1111;
                        end else begin
                            stg_d   = stg_q + 2'd1;
                            state_d = StRelease;
                        end
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                StDone: begin
                end
                StFault: begin
                end
                default: begin
                    state_d = StPor;
                    cnt_d   = 24'd0;
                    stg_d   = 2'd0;
                    prst_d  = 4'b0000;
                    done_d  = 1'b0;
                    fault_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StPor;
            cnt_q    <= 24'd0;
            stg_q    <= 2'd0;
            prst_q   <= 4'b0000;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            fstage_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stg_q    <= stg_d;
            prst_q   <= prst_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            fstage_q <= fstage_d;
        end
    end

    assign periph_rst_n = prst_q;
    assign seq_done     = done_q;
    assign seq_fault    = fault_q;
    assign fault_stage  = fstage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with POR=10, TIMEOUT=20, GAP=5.
// Edge counts below are rising edges since reset release (or since the edge
// that sampled restart); the state after that edge is POR with cnt=0.
module tb_reset_sequencer;

    logic       clk_50m;
    logic       rst_n;
    logic       restart;
    logic [3:0] periph_ready;
    logic [3:0] periph_rst_n;
    logic       seq_done;
    logic       seq_fault;
    logic [1:0] fault_stage;

    int n_cmp;
    int n_bad;

    reset_sequencer #(
        .POR_CYCLES    (24'd10),
        .TIMEOUT_CYCLES(24'd20),
        .GAP_CYCLES    (24'd5)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .restart     (restart),
        .periph_ready(periph_ready),
        .periph_rst_n(periph_rst_n),
        .seq_done    (seq_done),
        .seq_fault   (seq_fault),
        .fault_stage (fault_stage)
    );

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        restart      = 1'b0;
        periph_ready = 4'b1111;

        // Reset state
        tick(2);
        check_eq("rst_prst", 32'(periph_rst_n), 32'h0);
        check_eq("rst_done", 32'(seq_done), 32'h0);
        check_eq("rst_fault", 32'(seq_fault), 32'h0);
        check_eq("rst_fstage", 32'(fault_stage), 32'h0);
        rst_n = 1'b1;

        // All ready: bits rise after edges 11, 18, 25, 32; DONE after 38
        tick(10);
        check_eq("seq_e10", 32'(periph_rst_n), 32'h0);
        tick(1);
        check_eq("seq_e11", 32'(periph_rst_n), 32'h1);
        tick(6);
        check_eq("seq_e17", 32'(periph_rst_n), 32'h1);
        tick(1);
        check_eq("seq_e18", 32'(periph_rst_n), 32'h3);
        tick(7);
        check_eq("seq_e25", 32'(periph_rst_n), 32'h7);
        tick(7);
        check_eq("seq_e32", 32'(periph_rst_n), 32'hf);
        check_eq("seq_e32_done", 32'(seq_done), 32'h0);
        tick(5);
        check_eq("seq_e37_done", 32'(seq_done), 32'h0);
        tick(1);
        check_eq("seq_e38_done", 32'(seq_done), 32'h1);
        check_eq("seq_e38_fault", 32'(seq_fault), 32'h0);

        // DONE: ready[1] low for 3 cycles; seen after 2 sync edges + 1 FSM edge
        periph_ready = 4'b1101;
        tick(2);
        check_eq("drop_e2_fault", 32'(seq_fault), 32'h0);
        tick(1);
        check_eq("drop_e3_fault", 32'(seq_fault), 32'h1);
        check_eq("drop_e3_fstage", 32'(fault_stage), 32'h1);
        check_eq("drop_e3_prst", 32'(periph_rst_n), 32'h0);
        check_eq("drop_e3_done", 32'(seq_done), 32'h0);
        periph_ready = 4'b1111;
        tick(5);
        check_eq("drop_hold_fault", 32'(seq_fault), 32'h1);
        check_eq("drop_hold_fstage", 32'(fault_stage), 32'h1);

        // Restart from FAULT, then restart again in stage-1 GAP (edge 20)
        pulse_restart();
        check_eq("rsf_fault", 32'(seq_fault), 32'h0);
        check_eq("rsf_prst", 32'(periph_rst_n), 32'h0);
        tick(10);
        check_eq("rsf_e10", 32'(periph_rst_n), 32'h0);
        tick(1);
        check_eq("rsf_e11", 32'(periph_rst_n), 32'h1);
        tick(7);
        check_eq("rsf_e18", 32'(periph_rst_n), 32'h3);
        tick(2);
        pulse_restart();
        check_eq("rsg_prst", 32'(periph_rst_n), 32'h0);
        check_eq("rsg_fault", 32'(seq_fault), 32'h0);

        // ready[2] stuck low: WAIT_RDY stage 2 from edge 25, fault at edge 45
        periph_ready = 4'b1011;
        tick(11);
        check_eq("to_e11", 32'(periph_rst_n), 32'h1);
        tick(14);
        check_eq("to_e25", 32'(periph_rst_n), 32'h7);
        tick(19);
        check_eq("to_e44_fault", 32'(seq_fault), 32'h0);
        check_eq("to_e44_prst", 32'(periph_rst_n), 32'h7);
        tick(1);
        check_eq("to_e45_fault", 32'(seq_fault), 32'h1);
        check_eq("to_e45_fstage", 32'(fault_stage), 32'h2);
        check_eq("to_e45_prst", 32'(periph_rst_n), 32'h0);
        check_eq("to_e45_done", 32'(seq_done), 32'h0);

        // ready[0] synchronized high exactly when cnt reaches 19 (edge 30)
        periph_ready = 4'b1100;
        pulse_restart();
        check_eq("edge_rs_fstage", 32'(fault_stage), 32'h0);
        tick(28);
        periph_ready = 4'b1101;
        tick(2);
        check_eq("edge_e30_fault", 32'(seq_fault), 32'h0);
        tick(1);
        check_eq("edge_e31_fault", 32'(seq_fault), 32'h0);
        check_eq("edge_e31_prst", 32'(periph_rst_n), 32'h1);
        tick(5);
        check_eq("edge_e36_prst", 32'(periph_rst_n), 32'h1);
        tick(1);
        check_eq("edge_e37_prst", 32'(periph_rst_n), 32'h3);

        // rst_n pulse mid WAIT_RDY of stage 1
        tick(3);
        rst_n = 1'b0;
        #2;
        check_eq("arst_prst", 32'(periph_rst_n), 32'h0);
        check_eq("arst_fault", 32'(seq_fault), 32'h0);
        check_eq("arst_done", 32'(seq_done), 32'h0);
        tick(1);
        rst_n        = 1'b1;
        periph_ready = 4'b1111;
        tick(10);
        check_eq("arst_e10", 32'(periph_rst_n), 32'h0);
        tick(1);
        check_eq("arst_e11", 32'(periph_rst_n), 32'h1);
        check_eq("arst_e11_fault", 32'(seq_fault), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter POR_CYCLES, default 24'd2500000, power-on wait before stage 0 (50 ms at 50 MHz); legal range 1..2^24-1.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd500000, max wait for a stage ready (10 ms); legal range 1..2^24-1.
REQ-003 Parameter GAP_CYCLES, default 24'd50000, settle time after a stage ready (1 ms); legal range 1..2^24-1.
REQ-004 clk_50m  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 restart  input  1  synchronous, single-cycle soft restart request.
REQ-007 periph_ready  input  4  per-stage ready/ack from peripheral; asynchronous to clk_50m.
REQ-008 periph_rst_n  output  4  per-stage peripheral reset, active-low, registered.
REQ-009 seq_done  output  1  high while all 4 stages are released and healthy, registered.
REQ-010 seq_fault  output  1  high while in FAULT, registered.
REQ-011 fault_stage  output  2  index of the failing stage, valid while seq_fault=1, registered.

Function
REQ-012 periph_ready SHALL pass through a 2-flop synchronizer per bit; all references below to ready mean the synchronized value (2-cycle latency).
REQ-013 FSM states SHALL be POR, RELEASE, WAIT_RDY, GAP, DONE, FAULT; a 24-bit counter cnt and a 2-bit stage index stg SHALL be kept.
REQ-014 POR: cnt increments each cycle; on cnt==POR_CYCLES-1 -> RELEASE with cnt=0, stg=0.
REQ-015 RELEASE: one cycle; sets periph_rst_n[stg]=1 (visible next cycle); -> WAIT_RDY, cnt=0.
REQ-016 WAIT_RDY: if ready[stg]=1 -> GAP, cnt=0; else if cnt==TIMEOUT_CYCLES-1 -> FAULT with fault_stage=stg; else cnt++.
REQ-017 Ready and timeout in the same cycle: ready SHALL win (-> GAP).
REQ-018 GAP: cnt increments; on cnt==GAP_CYCLES-1: if stg==3 -> DONE, else stg++, -> RELEASE.
REQ-019 In WAIT_RDY, GAP and DONE, if any already-released stage j (j<stg, or j==stg after its ready was seen) drops ready -> FAULT with fault_stage = lowest such j.
REQ-020 DONE: seq_done=1, periph_rst_n=4'b1111; held until fault or restart.
REQ-021 FAULT: periph_rst_n=4'b0000, seq_fault=1, seq_done=0, fault_stage held; leaves only on restart or rst_n.
REQ-022 restart=1 in any state SHALL take priority: next state POR, cnt=0, stg=0, periph_rst_n=0, seq_done=0, seq_fault=0, fault_stage=0.
REQ-023 Stages release strictly in order 0,1,2,3; periph_rst_n[k] SHALL never be 1 while periph_rst_n[k-1] is 0.
REQ-024 cnt SHALL never wrap; comparisons are exact equality against parameter-1.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=POR, cnt=0, stg=0, synchronizers=0, periph_rst_n=4'b0000, seq_done=0, seq_fault=0, fault_stage=2'd0.
REQ-026 rst_n asserted mid-sequence SHALL abort immediately (all peripheral resets re-asserted); after release the sequence restarts from POR.

Verification (POR_CYCLES=10, TIMEOUT_CYCLES=20, GAP_CYCLES=5)
REQ-027 Reset release, all ready tied 1 -> periph_rst_n[0] rises 11 cycles after first edge; bits 1..3 follow at fixed spacing; seq_done=1 after stage 3 GAP; no fault.
REQ-028 periph_ready[2] held 0 -> after 20 WAIT_RDY cycles seq_fault=1, fault_stage=2, periph_rst_n=0000, seq_done=0.
REQ-029 In DONE, pulse periph_ready[1] low 3 cycles -> seq_fault=1, fault_stage=1 within 3 cycles of the drop; ready return does not clear fault.
REQ-030 ready[0] rises exactly on the cycle cnt reaches 19 -> GAP entered, no fault.
REQ-031 restart pulse while in FAULT and while in GAP of stage 1 -> next cycle periph_rst_n=0000, seq_fault=0; full sequence reruns from POR.
REQ-032 rst_n low for 1 cycle mid-WAIT_RDY -> outputs cleared asynchronously; sequence restarts, stage 0 released 11 cycles after release.
